// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity polarity
// constants and the parity helper used when a frame is loaded.
package uart_pkg;

    localparam int MAX_DATA_W = 9;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } tx_state_e;

    // Zero-extended data has the same parity as the original word.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                         input logic odd);
        logic p;
        p = 1'b0;
        case (odd)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = ^data;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; tick_o marks the last clock of a bit and
// the counter then reloads the divisor captured for the current frame.
module uart_bit_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] reload_val_i,
    output logic         tick_o
);

    logic [W-1:0] count_q, count_d;

    assign tick_o = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = tick_o ? reload_val_i : count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame_shifter.sv
// Parametrised UART transmit serialiser: accepts a word on valid/ready, builds
// start/data/parity/stop frame and shifts it out LSB first on tx_out.
module uart_tx_frame_shifter
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              two_stop,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int SR_W   = DATA_W + 4;
    localparam int BITS_W = $clog2(SR_W + 1);

    generate
        if (DATA_W < 5 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
            $error("uart_tx_frame_shifter: DATA_W must be within 5..9");
        end
    endgenerate

    tx_state_e         state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              done_q, done_d;

    logic                  timer_load, timer_en, timer_tick;
    logic [MAX_DATA_W-1:0] data_ext;
    logic                  par_bit;

    uart_bit_timer #(.W(DIV_W)) u_bit_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (timer_load),
        .load_val_i   (baud_div),
        .en_i         (timer_en),
        .reload_val_i (div_q),
        .tick_o       (timer_tick)
    );

    // Without parity the parity slot carries a 1 and simply acts as a stop bit.
    always_comb begin
        data_ext = '0;
        data_ext[DATA_W-1:0] = tx_data;
        par_bit = par_en ? calc_parity(data_ext, par_odd) : 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bits_d     = bits_q;
        div_d      = div_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    sr_d       = {2'b11, par_bit, tx_data, 1'b0};
                    bits_d     = BITS_W'(DATA_W + 2) + BITS_W'(par_en) + BITS_W'(two_stop);
                    div_d      = baud_div;
                    timer_load = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                timer_en = 1'b1;
                if (timer_tick) begin
                    sr_d   = {1'b1, sr_q[SR_W-1:1]};
                    bits_d = bits_q - BITS_W'(1);
                    if (bits_q == BITS_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '1;
            bits_q  <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bits_q  <= bits_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    assign tx_out   = sr_q[0];
    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_SHIFT);
    assign done     = done_q;

endmodule

// File: doc/uart_tx_frame_shifter.md
Name: uart_tx_frame_shifter

Overview:
- Parametrised transmit serialiser for the UART/TSI datapath; successor to the fixed 11-bit TX shift register.
- Accepts one data word over a valid/ready handshake and builds the frame: start bit, DATA_W data bits LSB first, optional parity, then 1 or 2 stop bits.
- Shifts the frame out on tx_out using an internal bit-period timer, so the TX engine no longer drives LD/SH strobes.
- Sits between the TX FIFO/controller and the pad.

Parameters:
DATA_W, 8, data bits per frame (5..9 legal)
DIV_W, 16, width of bit-period divisor port
SR_W, DATA_W+4, derived localparam; shift register width (start + data + parity + 2 stop)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
baud_div  in  DIV_W  clocks per bit minus 1
par_en  in  1  1 = append parity bit
par_odd  in  1  1 = odd parity, 0 = even (ignored if par_en=0)
two_stop  in  1  1 = two stop bits
tx_data  in  DATA_W  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept a word (high only in IDLE)
tx_out  out  1  serial line, idle high
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last stop bit completes

Behaviour:
- One clock (clk); reset is synchronous and active-high. On reset at a clk edge:
  - state=IDLE, shift register = all 1s, so tx_out=1 from that edge.
  - tx_ready=1, busy=0, done=0, bit timer and bit counter = 0.
- States:
  - IDLE: tx_ready=1.
  - SHIFT: tx_ready=0, busy=1.
- Accept occurs when tx_valid & tx_ready at a clk edge. At that edge:
  - Load SR = {1, s2, p, tx_data, 0}. s2 = 1. p = parity when par_en=1, else 1.
  - Parity: even gives p = ^tx_data; odd gives p = ~^tx_data.
  - bits_left = 1 + DATA_W + par_en + 1 + two_stop.
  - timer = baud_div; state = SHIFT.
  - Capture par_en, par_odd, two_stop and baud_div into internal registers. Changes to these inputs during a frame have no effect.
- tx_out = SR[0], registered; start bit (0) appears the edge after accept.
- In SHIFT, each clk:
  - If timer != 0: timer decrements.
  - If timer == 0: SR <= {1, SR[SR_W-1:1]}, bits_left decrements, timer reloads the captured divisor.
  - When bits_left reaches 0 on that shift: state becomes IDLE, done=1 for exactly one cycle, tx_out stays 1.
- Each bit lasts exactly baud_div+1 clocks. Frame lasts bits_left_initial*(baud_div+1) clocks from accept edge to done edge.
- baud_div=0 is legal: one bit per clock.
- Back-to-back frames: tx_ready rises on the same edge that done pulses. A word held on tx_valid is accepted at the next edge, so there is no idle gap beyond the stop bits.
- tx_valid while busy is ignored and nothing is latched. The producer must hold tx_data until the accept edge.
- Reset mid-frame aborts the frame: tx_out=1 at the next edge and no done pulse.
- Reset has priority over accept and shift.
- DATA_W outside 5..9 is a configuration error; flag it with an elaboration-time check.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding ST_IDLE, ST_SHIFT;
  - parity helper function calc_parity(data, odd);
  - constants PAR_EVEN=0, PAR_ODD=1.
- One sub-module, uart_bit_timer: a loadable down-counter with a tick output asserted at 0, which reloads the divisor. Frame/state logic stays in the top module.

Test Plan:
- DATA_W=8, baud_div=3, par_en=0, two_stop=0, send 8'hA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks; done pulses 40 clocks after accept; tx_ready low for those 40.
- Same word with par_en=1, par_odd=0 -> parity bit 0, 11 bits, done at 44 clocks; with par_odd=1 -> parity bit 1.
- two_stop=1, par_en=1, baud_div=0, send 8'h00 -> 12 bits at 1 clock each: 0×9, parity 0 (even), 1,1; done at clock 12.
- Hold tx_valid high with words 8'h01 then 8'h80 -> second start bit begins the edge after done; tx_valid during busy produces no corruption.
- Assert reset 10 clocks into a baud_div=3 frame -> tx_out=1 next edge, busy=0, tx_ready=1, no done; a new 8'h3C frame after reset is bit-exact.
- Change baud_div 7→1 and par_en mid-frame -> current frame keeps the old timing and format; the next frame uses the new values.
